// File: rtl/pong_game_ctrl.sv
// Match sequencer for the VGA pong game: it runs the game FSM, the serve and game-over
// delay timer, the BCD scores and the ball budget. It also drives the graphics freeze
// and the text banner enables.
module pong_game_ctrl #(
  parameter int BALLS      = 7,
  parameter int WIN_SCORE  = 11,
  parameter int FRAME_WAIT = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] btn,
  input  logic       pts_1,
  input  logic       pts_2,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [6:0] balls_left,
  output logic [3:0] p1_dig1,
  output logic [3:0] p1_dig0,
  output logic [3:0] p2_dig1,
  output logic [3:0] p2_dig0,
  output logic       show_title,
  output logic       show_over
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [7:0] WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [6:0] BALLS_INIT = 7'(BALLS);
  localparam logic [7:0] WAIT_INIT  = 8'(FRAME_WAIT);

  state_t     state;
  logic [7:0] timer;
  logic       btn_prev;
  logic       btn_press;
  logic       timer_up;
  logic       point;
  logic [7:0] cur_score;
  logic [7:0] new_score;
  logic [6:0] new_balls;
  logic       end_game;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // pts_1 takes priority, so a simultaneous pts_2 is simply dropped.
  always_comb begin
    btn_press = (|btn) & ~btn_prev;
    timer_up  = (timer == 8'd0);
    point     = (state == PLAY) && (pts_1 || pts_2);
    cur_score = pts_1 ? {p1_dig1, p1_dig0} : {p2_dig1, p2_dig0};
    new_score = bcd_inc(cur_score);
    new_balls = balls_left - 7'd1;
    end_game  = (new_score == WIN_BCD) || (new_balls == 7'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NEWGAME;
      timer      <= 8'd0;
      btn_prev   <= 1'b0;
      balls_left <= BALLS_INIT;
      p1_dig1    <= 4'd0;
      p1_dig0    <= 4'd0;
      p2_dig1    <= 4'd0;
      p2_dig0    <= 4'd0;
    end else begin
      btn_prev <= |btn;
      if (point)
        timer <= WAIT_INIT;
      else if (frame_tick && !timer_up)
        timer <= timer - 8'd1;

      case (state)
        NEWGAME: begin
          p1_dig1    <= 4'd0;
          p1_dig0    <= 4'd0;
          p2_dig1    <= 4'd0;
          p2_dig0    <= 4'd0;
          balls_left <= BALLS_INIT;
          if (btn_press) state <= PLAY;
        end
        PLAY: begin
          if (point) begin
            if (pts_1) {p1_dig1, p1_dig0} <= new_score;
            else       {p2_dig1, p2_dig0} <= new_score;
            balls_left <= new_balls;
            state      <= end_game ? OVER : NEWBALL;
          end
        end
        NEWBALL: if (btn_press && timer_up) state <= PLAY;
        OVER:    if (timer_up) state <= NEWGAME;
        default: state <= NEWGAME;
      endcase
    end
  end

  // The banner enables and the freeze flag decode the state register directly.
  assign game_state = state;
  assign gra_still  = (state != PLAY);
  assign show_title = (state == NEWGAME);
  assign show_over  = (state == OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Random-stimulus bench for pong_game_ctrl. Three parameterisations share the same inputs.
// Each one is compared every cycle against an integer-level model of the match rules.
module tb_pong_game_ctrl;

  localparam int NI = 3;
  localparam int PB[NI] = '{7, 2, 30};
  localparam int PW[NI] = '{11, 11, 11};
  localparam int PF[NI] = '{120, 3, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [3:0] btn;
  logic       pts_1;
  logic       pts_2;

  logic       gra_still[NI];
  logic [1:0] game_state[NI];
  logic [6:0] balls_left[NI];
  logic [3:0] p1_dig1[NI];
  logic [3:0] p1_dig0[NI];
  logic [3:0] p2_dig1[NI];
  logic [3:0] p2_dig0[NI];
  logic       show_title[NI];
  logic       show_over[NI];

  int checks = 0;
  int failures = 0;
  logic [27:0] exp_q[$];

  // model: 0 = title screen, 1 = rally, 2 = waiting to serve, 3 = game over
  int m_phase[NI];
  int m_p1[NI];
  int m_p2[NI];
  int m_balls[NI];
  int m_timer[NI];
  bit m_btn_held;

  always #5 clk = ~clk;

  pong_game_ctrl #(.BALLS(PB[0]), .WIN_SCORE(PW[0]), .FRAME_WAIT(PF[0])) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .pts_1(pts_1), .pts_2(pts_2),
    .gra_still(gra_still[0]), .game_state(game_state[0]), .balls_left(balls_left[0]),
    .p1_dig1(p1_dig1[0]), .p1_dig0(p1_dig0[0]), .p2_dig1(p2_dig1[0]), .p2_dig0(p2_dig0[0]),
    .show_title(show_title[0]), .show_over(show_over[0]));

  pong_game_ctrl #(.BALLS(PB[1]), .WIN_SCORE(PW[1]), .FRAME_WAIT(PF[1])) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .pts_1(pts_1), .pts_2(pts_2),
    .gra_still(gra_still[1]), .game_state(game_state[1]), .balls_left(balls_left[1]),
    .p1_dig1(p1_dig1[1]), .p1_dig0(p1_dig0[1]), .p2_dig1(p2_dig1[1]), .p2_dig0(p2_dig0[1]),
    .show_title(show_title[1]), .show_over(show_over[1]));

  pong_game_ctrl #(.BALLS(PB[2]), .WIN_SCORE(PW[2]), .FRAME_WAIT(PF[2])) dut_c (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .pts_1(pts_1), .pts_2(pts_2),
    .gra_still(gra_still[2]), .game_state(game_state[2]), .balls_left(balls_left[2]),
    .p1_dig1(p1_dig1[2]), .p1_dig0(p1_dig0[2]), .p2_dig1(p2_dig1[2]), .p2_dig0(p2_dig0[2]),
    .show_title(show_title[2]), .show_over(show_over[2]));

  function automatic logic [27:0] got_word(input int i);
    return {game_state[i], gra_still[i], balls_left[i], p1_dig1[i], p1_dig0[i],
            p2_dig1[i], p2_dig0[i], show_title[i], show_over[i]};
  endfunction

  function automatic logic [27:0] exp_word(input int i);
    return {2'(m_phase[i]), 1'(m_phase[i] != 1), 7'(m_balls[i]),
            4'(m_p1[i] / 10), 4'(m_p1[i] % 10), 4'(m_p2[i] / 10), 4'(m_p2[i] % 10),
            1'(m_phase[i] == 0), 1'(m_phase[i] == 3)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_btn_held = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_phase[i] = 0;
      m_p1[i]    = 0;
      m_p2[i]    = 0;
      m_balls[i] = PB[i];
      m_timer[i] = 0;
    end
  endtask

  task automatic model_step(input bit ft, input logic [3:0] b, input bit q1, input bit q2);
    bit press;
    bit expired;
    bit reload;
    int s;
    press = (b != 4'd0) && !m_btn_held;
    m_btn_held = (b != 4'd0);
    for (int i = 0; i < NI; i++) begin
      expired = (m_timer[i] == 0);
      reload = 1'b0;
      case (m_phase[i])
        0: begin
          m_p1[i] = 0;
          m_p2[i] = 0;
          m_balls[i] = PB[i];
          if (press) m_phase[i] = 1;
        end
        1: if (q1 || q2) begin
          if (q1) begin
            m_p1[i] = (m_p1[i] < 99) ? m_p1[i] + 1 : 99;
            s = m_p1[i];
          end else begin
            m_p2[i] = (m_p2[i] < 99) ? m_p2[i] + 1 : 99;
            s = m_p2[i];
          end
          m_balls[i]--;
          reload = 1'b1;
          m_phase[i] = (s == PW[i] || m_balls[i] == 0) ? 3 : 2;
        end
        2: if (press && expired) m_phase[i] = 1;
        default: if (expired) m_phase[i] = 0;
      endcase
      if (reload) m_timer[i] = PF[i];
      else if (ft && m_timer[i] > 0) m_timer[i]--;
    end
  endtask

  task automatic push_all();
    for (int i = 0; i < NI; i++) exp_q.push_back(exp_word(i));
  endtask

  initial begin
    reset = 1'b0;
    frame_tick = 1'b0;
    btn = 4'd0;
    pts_1 = 1'b0;
    pts_2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    push_all();
    for (int n = 0; n < 20000; n++) begin
      for (int i = 0; i < NI; i++)
        check($sformatf("inst%0d_cyc%0d", i, n), 32'(got_word(i)), 32'(exp_q.pop_front()));
      if ($urandom_range(0, 2499) == 0) begin
        // Asynchronous reset lands mid-cycle; outputs must fall back before the next edge.
        frame_tick = 1'b0;
        btn = 4'd0;
        pts_1 = 1'b0;
        pts_2 = 1'b0;
        #2 reset = 1'b0;
        #1 model_reset();
        for (int i = 0; i < NI; i++)
          check($sformatf("inst%0d_async_rst_%0d", i, n), 32'(got_word(i)), 32'(exp_word(i)));
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        push_all();
        continue;
      end
      frame_tick = ($urandom_range(0, 1) == 1);
      pts_1 = ($urandom_range(0, 7) == 0);
      pts_2 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        btn = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      model_step(frame_tick, btn, pts_1, pts_2);
      push_all();
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
